// File: rtl/alu_pkg.sv
// alu_pkg: shared types and defaults for the sequential ALU adder/subtractor.
package alu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SEQ_ADDSUB_WIDTH      = 32;
    localparam int SEQ_ADDSUB_CHUNK      = 8;
    localparam int SEQ_ADDSUB_MAX_CHUNKS = 16;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: W-bit combinational ripple chain of full_adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    assign cout = c[W];
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
    end
endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Define SEQ_ADDSUB_SAT_EN to clamp overflowing results to the signed limit.
module seq_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = SEQ_ADDSUB_WIDTH,
    parameter int CHUNK = SEQ_ADDSUB_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N   = WIDTH / CHUNK;
    localparam int MSB = WIDTH - 1;

    if (WIDTH % CHUNK != 0 || N > SEQ_ADDSUB_MAX_CHUNKS) begin : g_bad_cfg
        $error("seq_addsub: WIDTH must be a multiple of CHUNK with at most 16 chunks");
    end

    state_t           state, state_nx;
    logic [3:0]       cnt;
    logic             carry, last, chunk_co, ovf_nx;
    logic [CHUNK-1:0] chunk_sum;
    logic [WIDTH-1:0] opa, opb, sum_reg, sum_nx, sum_fin;

    chunk_adder #(.W(CHUNK)) u_chunk (
        .a    (opa[int'(cnt)*CHUNK +: CHUNK]),
        .b    (opb[int'(cnt)*CHUNK +: CHUNK]),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_co)
    );

    assign last      = cnt == 4'(N - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sum       = sum_reg;

    always_comb begin
        sum_nx = sum_reg;
        sum_nx[int'(cnt)*CHUNK +: CHUNK] = chunk_sum;
    end

    assign ovf_nx = (opa[MSB] == opb[MSB]) && (sum_nx[MSB] != opa[MSB]);

`ifdef SEQ_ADDSUB_SAT_EN
    assign sum_fin = ovf_nx ? {opa[MSB], {(WIDTH-1){~opa[MSB]}}} : sum_nx;
`else
    assign sum_fin = sum_nx;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid  ? RUN  : IDLE;
            RUN:     state_nx = last      ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // B is inverted once at accept so every chunk sees plain addition
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            carry   <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            sum_reg <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_reg <= last ? sum_fin : sum_nx;
            carry   <= chunk_co;
            cnt     <= cnt + 4'd1;
            if (last) begin
                cout <= chunk_co;
                ovf  <= ovf_nx;
                zero <= sum_fin == '0;
            end
        end
    end
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: checks CHUNK=8, 32 and 4 instances side by side against an arithmetic model.
module tb_seq_addsub;
    typedef struct {
        logic [31:0] a, b;
        logic        sub, cin;
        logic [31:0] s;
        logic        co, ov, z;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, sub, cin, out_ready;
    logic [31:0] a, b;
    logic        in_ready[3], out_valid[3], cout_o[3], ovf_o[3], zero_o[3];
    logic [31:0] sum_o[3];
    int          lat[3] = '{4, 1, 8};
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = g == 0 ? 8 : g == 1 ? 32 : 4;
        seq_addsub #(.WIDTH(32), .CHUNK(CH)) dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[g]),
            .a(a), .b(b), .sub(sub), .cin(cin),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .sum(sum_o[g]), .cout(cout_o[g]), .ovf(ovf_o[g]), .zero(zero_o[g])
        );
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operands, signed range test for overflow.
    function automatic vec_t model(input logic [31:0] a_i, b_i, input logic sub_i, cin_i);
        vec_t        v;
        logic [31:0] bb;
        longint      u, s;
        bb = sub_i ? ~b_i : b_i;
        u = longint'({32'd0, a_i}) + longint'({32'd0, bb}) + longint'(cin_i);
        s = longint'($signed(a_i)) + longint'($signed(bb)) + longint'(cin_i);
        v.a = a_i; v.b = b_i; v.sub = sub_i; v.cin = cin_i;
        v.s  = u[31:0];
        v.co = u[32];
        v.ov = s > 64'sd2147483647 || s < -64'sd2147483648;
`ifdef SEQ_ADDSUB_SAT_EN
        if (s > 64'sd2147483647) v.s = 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) v.s = 32'h8000_0000;
`endif
        v.z = v.s == 32'd0;
        return v;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_wait", 32'(t < 20), 32'd1);
    endtask

    task automatic run_op(input vec_t v, input bit hold);
        wait_ready();
        out_ready = !hold;
        a = v.a; b = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("valid_d%0d_k%0d", d, k), 32'(out_valid[d]), 32'(hold ? k >= lat[d] : k == lat[d]));
                if (k == lat[d]) begin
                    chk($sformatf("sum_d%0d_%h_%h", d, v.a, v.b), sum_o[d], v.s);
                    chk($sformatf("cout_d%0d", d), 32'(cout_o[d]), 32'(v.co));
                    chk($sformatf("ovf_d%0d", d), 32'(ovf_o[d]), 32'(v.ov));
                    chk($sformatf("zero_d%0d", d), 32'(zero_o[d]), 32'(v.z));
                end
            end
        end
    endtask

    task automatic chk_idle(input string n);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_ready_d%0d", n, d), 32'(in_ready[d]), 32'd1);
            chk($sformatf("%s_valid_d%0d", n, d), 32'(out_valid[d]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
`ifdef SEQ_ADDSUB_SAT_EN
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif
        tbl[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_idle("reset");
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_sum_d%0d", d), sum_o[d], 32'd0);
            chk($sformatf("reset_flags_d%0d", d), {29'd0, cout_o[d], ovf_o[d], zero_o[d]}, 32'd0);
        end

        foreach (tbl[i]) run_op(tbl[i], 1'b0);

        // Back-pressure: results must hold for as long as out_ready stays low.
        v = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
        run_op(v, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("hold_valid_d%0d", d), 32'(out_valid[d]), 32'd1);
                chk($sformatf("hold_ready_d%0d", d), 32'(in_ready[d]), 32'd0);
                chk($sformatf("hold_sum_d%0d", d), sum_o[d], v.s);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_idle("release");

        // Reset on the second RUN cycle discards the operation.
        wait_ready();
        a = 32'h0F0F_0F0F; b = 32'h1111_1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle("midrun_reset");
        for (int d = 0; d < 3; d++) chk($sformatf("midrun_reset_sum_d%0d", d), sum_o[d], 32'd0);
        run_op(model(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b1), 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 5 == 0) ? ~ra : $urandom;
            run_op(model(ra, rb, 1'($urandom), 1'($urandom)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
